traffic_gen_monitor: RTL and testbench

- Synthesisable, parametrised request generator and monitor for the core-array allocator.
- Drives N_CH independent request channels with LFSR-derived payloads, in one of three selectable traffic modes.
- Checks grants returned by the allocator, counts completed handshakes per channel, and flags starvation and protocol errors.
- Replaces the fixed-size random pulse source in the top-level harness for arrays larger than 2x2.

---
 rtl/traffic_gen_monitor_if.sv | 12 +
 rtl/traffic_gen_monitor.sv | 165 ++++++++++++++++
 tb/tb_traffic_gen_monitor.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_gen_monitor_if.sv
// rtl/traffic_gen_monitor_if.sv - request/grant bundle between generator and allocator
interface traffic_gen_monitor_if #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8
);
    logic [N_CH-1:0]        req_o;
    logic [N_CH*DATA_W-1:0] data_o;
    logic [N_CH-1:0]        gnt_i;

    modport master (output req_o, output data_o, input gnt_i);
    modport slave  (input req_o, input data_o, output gnt_i);
endinterface

// File: rtl/traffic_gen_monitor.sv
// rtl/traffic_gen_monitor.sv - LFSR-driven request generator and grant monitor
module traffic_gen_monitor #(
    parameter int         DATA_W     = 8,
    parameter int         N_CH       = 4,
    parameter logic [7:0] SEED       = 8'hA5,
    parameter int         BURST_LEN  = 4,
    parameter int         STARVE_LIM = 16,
    parameter int         CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [1:0]                mode,
    input  logic [DATA_W-1:0]         density,
    traffic_gen_monitor_if.master     bus,
    output logic [N_CH*CNT_W-1:0]     hs_cnt_o,
    output logic [N_CH-1:0]           starve_o,
    output logic                      err_o
);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int WW = $clog2(STARVE_LIM + 1);

    typedef enum logic [1:0] {IDLE, REQ, BURST_REQ} ch_state_e;

    ch_state_e          state_q [N_CH];
    ch_state_e          state_d [N_CH];
    logic [7:0]         lfsr_q  [N_CH];
    logic [7:0]         lfsr_d  [N_CH];
    logic [DATA_W-1:0]  data_q  [N_CH];
    logic [DATA_W-1:0]  data_d  [N_CH];
    logic [BW-1:0]      bcnt_q  [N_CH];
    logic [BW-1:0]      bcnt_d  [N_CH];
    logic [WW-1:0]      wait_q  [N_CH];
    logic [WW-1:0]      wait_d  [N_CH];
    logic [CNT_W-1:0]   hs_q    [N_CH];
    logic [CNT_W-1:0]   hs_d    [N_CH];
    logic [N_CH-1:0]    req_q;
    logic [N_CH-1:0]    req_d;
    logic [N_CH-1:0]    starve_d;
    logic [N_CH-1:0]    xfer;
    logic               err_d;

    function automatic logic [7:0] seed_of(input int i);
        logic [7:0] s;
        s = SEED ^ 8'(i + 1);
        return (s == 8'h00) ? 8'h01 : s;
    endfunction

    // x^8 + x^6 + x^5 + x^4 + 1, shifting towards the MSB
    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [DATA_W-1:0] payload_of(input logic [7:0] l);
        logic [DATA_W-1:0] p;
        for (int b = 0; b < DATA_W; b++) p[b] = l[b % 8];
        return p;
    endfunction

    always_comb begin
        xfer  = req_q & bus.gnt_i;
        err_d = err_o | (|(bus.gnt_i & ~req_q));
        req_d = req_q;
        starve_d = starve_o;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            lfsr_d[i]  = en ? lfsr_next(lfsr_q[i]) : lfsr_q[i];
            data_d[i]  = data_q[i];
            bcnt_d[i]  = bcnt_q[i];
            wait_d[i]  = wait_q[i];
            hs_d[i]    = hs_q[i];

            case (state_q[i])
                IDLE: begin
                    if (en) begin
                        case (mode)
                            2'd1: if (payload_of(lfsr_q[i]) < density) begin
                                state_d[i] = REQ;
                                req_d[i]   = 1'b1;
                                data_d[i]  = payload_of(lfsr_q[i]);
                            end
                            2'd2: if (payload_of(lfsr_q[i]) < density) begin
                                state_d[i] = BURST_REQ;
                                req_d[i]   = 1'b1;
                                data_d[i]  = payload_of(lfsr_q[i]);
                                bcnt_d[i]  = BW'(BURST_LEN);
                            end
                            2'd3: begin
                                state_d[i] = REQ;
                                req_d[i]   = 1'b1;
                                data_d[i]  = payload_of(lfsr_q[i]);
                            end
                            default: ;
                        endcase
                    end
                end
                REQ: begin
                    if (xfer[i]) begin
                        state_d[i] = IDLE;
                        req_d[i]   = 1'b0;
                    end
                end
                BURST_REQ: begin
                    // req drops for one cycle after each beat; the next payload is
                    // staged during that gap and the burst finishes regardless of en/mode
                    if (xfer[i]) begin
                        req_d[i]  = 1'b0;
                        bcnt_d[i] = bcnt_q[i] - 1'b1;
                        if (bcnt_q[i] == BW'(1)) state_d[i] = IDLE;
                        else                      data_d[i]  = payload_of(lfsr_q[i]);
                    end else if (!req_q[i]) begin
                        req_d[i] = 1'b1;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    req_d[i]   = 1'b0;
                end
            endcase

            if (xfer[i])
                wait_d[i] = '0;
            else if (req_q[i] && wait_q[i] != WW'(STARVE_LIM))
                wait_d[i] = wait_q[i] + 1'b1;
            if (wait_d[i] == WW'(STARVE_LIM)) starve_d[i] = 1'b1;

            if (xfer[i] && hs_q[i] != {CNT_W{1'b1}}) hs_d[i] = hs_q[i] + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q    <= '0;
            starve_o <= '0;
            err_o    <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= IDLE;
                lfsr_q[i]  <= seed_of(i);
                data_q[i]  <= '0;
                bcnt_q[i]  <= '0;
                wait_q[i]  <= '0;
                hs_q[i]    <= '0;
            end
        end else begin
            req_q    <= req_d;
            starve_o <= starve_d;
            err_o    <= err_d;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                lfsr_q[i]  <= lfsr_d[i];
                data_q[i]  <= data_d[i];
                bcnt_q[i]  <= bcnt_d[i];
                wait_q[i]  <= wait_d[i];
                hs_q[i]    <= hs_d[i];
            end
        end
    end

    assign bus.req_o = req_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_out
        assign bus.data_o[g*DATA_W +: DATA_W] = data_q[g];
        assign hs_cnt_o[g*CNT_W +: CNT_W]     = hs_q[g];
    end
endmodule

// File: tb/tb_traffic_gen_monitor.sv
// tb/tb_traffic_gen_monitor.sv - directed self-checking bench for traffic_gen_monitor
module tb_traffic_gen_monitor;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] density = 8'h00;
    logic [63:0] hs_cnt_o;
    logic [3:0]  starve_o;
    logic        err_o;
    int checks = 0;
    int errors = 0;

    traffic_gen_monitor_if #(.N_CH(4), .DATA_W(8)) bus ();

    traffic_gen_monitor dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .density(density),
        .bus(bus), .hs_cnt_o(hs_cnt_o), .starve_o(starve_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] seed_of(input int i);
        logic [7:0] s;
        s = 8'hA5 ^ 8'(i + 1);
        return (s == 8'h00) ? 8'h01 : s;
    endfunction

    function automatic logic [7:0] step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; en = 1'b0; mode = 2'd0; density = 8'h00; bus.gnt_i = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if (bus.req_o !== 4'b0000) begin errors++; $display("FAIL reset_req: got %b expected 0000", bus.req_o); end
        checks++;
        if (hs_cnt_o !== 64'h0 || starve_o !== 4'h0 || err_o !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: got hs=%h starve=%b err=%b expected all zero", hs_cnt_o, starve_o, err_o);
        end
    endtask

    task automatic test_density_zero;
        do_reset();
        // grants held low: a grant without a request is itself a protocol error
        mode = 2'd1; density = 8'h00; en = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            for (int c = 0; c < 200; c++) begin
                tick();
                if (bus.req_o !== 4'b0000) seen = 1'b1;
            end
            checks++;
            if (seen) begin errors++; $display("FAIL dens0_req: got request seen=1 expected 0"); end
        end
        checks++;
        if (hs_cnt_o !== 64'h0 || err_o !== 1'b0) begin
            errors++; $display("FAIL dens0_cnt: got hs=%h err=%b expected 0 0", hs_cnt_o, err_o);
        end
    endtask

    task automatic test_saturate;
        do_reset();
        mode = 2'd3; en = 1'b1; bus.gnt_i = 4'b1111;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (k == 1) begin
                for (int i = 0; i < 4; i++) begin
                    checks++;
                    if (bus.data_o[i*8 +: 8] !== seed_of(i)) begin
                        errors++; $display("FAIL sat_first_payload ch%0d: got %h expected %h", i, bus.data_o[i*8 +: 8], seed_of(i));
                    end
                end
            end
            if (k == 3) begin
                checks++;
                if (bus.data_o[7:0] !== 8'h91) begin errors++; $display("FAIL sat_second_payload ch0: got %h expected 91", bus.data_o[7:0]); end
                for (int i = 1; i < 4; i++) begin
                    checks++;
                    if (bus.data_o[i*8 +: 8] !== step(step(seed_of(i)))) begin
                        errors++; $display("FAIL sat_second_payload ch%0d: got %h expected %h", i, bus.data_o[i*8 +: 8], step(step(seed_of(i))));
                    end
                end
            end
        end
        mode = 2'd0; en = 1'b0; bus.gnt_i = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (hs_cnt_o[i*16 +: 16] !== 16'd25) begin
                errors++; $display("FAIL sat_count ch%0d: got %0d expected 25", i, hs_cnt_o[i*16 +: 16]);
            end
        end
    endtask

    task automatic test_starvation;
        do_reset();
        mode = 2'd3; en = 1'b1; bus.gnt_i = 4'b0000;
        tick();
        checks++;
        if (bus.req_o !== 4'b1111) begin errors++; $display("FAIL starve_req: got %b expected 1111", bus.req_o); end
        for (int c = 0; c < 15; c++) tick();
        checks++;
        if (starve_o !== 4'b0000) begin errors++; $display("FAIL starve_early: got %b expected 0000", starve_o); end
        tick();
        checks++;
        if (starve_o !== 4'b1111) begin errors++; $display("FAIL starve_set: got %b expected 1111", starve_o); end
        bus.gnt_i = 4'b0001;
        tick();
        bus.gnt_i = 4'b0000;
        checks++;
        if (hs_cnt_o[15:0] !== 16'd1 || starve_o[0] !== 1'b1 || bus.req_o[0] !== 1'b0) begin
            errors++; $display("FAIL starve_grant: got hs0=%0d starve0=%b req0=%b expected 1 1 0", hs_cnt_o[15:0], starve_o[0], bus.req_o[0]);
        end
        checks++;
        if (err_o !== 1'b0) begin errors++; $display("FAIL starve_err: got %b expected 0", err_o); end
    endtask

    task automatic test_burst;
        int         grants;
        logic       waited;
        logic       first;
        logic [7:0] held;
        do_reset();
        mode = 2'd2; density = 8'hFF; en = 1'b1;
        grants = 0; waited = 1'b0; first = 1'b1; held = 8'h00;
        for (int c = 0; c < 40; c++) begin
            tick();
            bus.gnt_i = 4'b0000;
            if (bus.req_o[1]) begin
                mode = 2'd0;
                if (first) begin
                    checks++;
                    if (bus.data_o[15:8] !== seed_of(1)) begin errors++; $display("FAIL burst_first_payload: got %h expected %h", bus.data_o[15:8], seed_of(1)); end
                    first = 1'b0;
                end
                if (!waited) begin
                    held = bus.data_o[15:8];
                    waited = 1'b1;
                end else begin
                    checks++;
                    if (bus.data_o[15:8] !== held) begin errors++; $display("FAIL burst_stable: got %h expected %h", bus.data_o[15:8], held); end
                    bus.gnt_i = 4'b0010;
                    waited = 1'b0;
                    grants++;
                end
            end
        end
        checks++;
        if (grants != 4) begin errors++; $display("FAIL burst_beats: got %0d expected 4", grants); end
        checks++;
        if (hs_cnt_o[31:16] !== 16'd4 || bus.req_o[1] !== 1'b0) begin
            errors++; $display("FAIL burst_done: got hs1=%0d req1=%b expected 4 0", hs_cnt_o[31:16], bus.req_o[1]);
        end
    endtask

    task automatic test_protocol_error;
        do_reset();
        bus.gnt_i = 4'b0100;
        checks++;
        if (err_o !== 1'b0) begin errors++; $display("FAIL perr_before: got %b expected 0", err_o); end
        tick();
        bus.gnt_i = 4'b0000;
        checks++;
        if (err_o !== 1'b1) begin errors++; $display("FAIL perr_set: got %b expected 1", err_o); end
        for (int c = 0; c < 5; c++) tick();
        checks++;
        if (err_o !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %b expected 1", err_o); end
        rst = 1'b1;
        #1;
        checks++;
        if (err_o !== 1'b0) begin errors++; $display("FAIL perr_clear: got %b expected 0", err_o); end
    endtask

    task automatic test_reset_mid_burst;
        do_reset();
        mode = 2'd2; density = 8'hFF; en = 1'b1;
        tick();
        bus.gnt_i = 4'b1111;
        tick();
        bus.gnt_i = 4'b0000;
        tick();
        checks++;
        if (hs_cnt_o[15:0] !== 16'd1) begin errors++; $display("FAIL midrst_pre: got hs0=%0d expected 1", hs_cnt_o[15:0]); end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.req_o !== 4'b0000 || hs_cnt_o !== 64'h0 || starve_o !== 4'h0 || err_o !== 1'b0) begin
            errors++; $display("FAIL midrst_async: got req=%b hs=%h starve=%b err=%b expected all zero", bus.req_o, hs_cnt_o, starve_o, err_o);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (bus.req_o !== 4'b1111) begin errors++; $display("FAIL midrst_req: got %b expected 1111", bus.req_o); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.data_o[i*8 +: 8] !== seed_of(i)) begin
                errors++; $display("FAIL midrst_payload ch%0d: got %h expected %h", i, bus.data_o[i*8 +: 8], seed_of(i));
            end
        end
    endtask

    initial begin
        bus.gnt_i = 4'b0000;
        test_reset();
        test_density_zero();
        test_saturate();
        test_starvation();
        test_burst();
        test_protocol_error();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
